// File: rtl/csr_counter_bank.sv
// csr_counter_bank: machine counter/timer CSR bank.
//   Holds mcycle, minstret and NUM_HPM programmable mhpmcounterN (N = 3..),
//   plus mcountinhibit, mhpmeventN and mcountovf. Reads have zero latency
//   and are decoded combinationally. Writes take effect on the rising edge
//   of clk, and a write to a counter takes priority over its increment.
// Ports:
//   clk, rst (async, active-low)
//   csrWriteEnable/csrWriteAddress/csrWriteData  CSR write request
//   csrReadEnable/csrReadAddress                 CSR read request
//   csrReadData/csrRequestOutput                 read data / address-owned flag
//   instructionCompleted                         retire pulse for minstret
//   events[NUM_EVENTS-1:0]                       HPM event strobes
//   overflowInterrupt                            OR of enabled overflow flags
module csr_counter_bank #(
  parameter int unsigned NUM_HPM       = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned NUM_EVENTS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csrWriteEnable,
  input  logic [11:0]           csrWriteAddress,
  input  logic [31:0]           csrWriteData,
  input  logic                  csrReadEnable,
  input  logic [11:0]           csrReadAddress,
  output logic [31:0]           csrReadData,
  output logic                  csrRequestOutput,
  input  logic                  instructionCompleted,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  overflowInterrupt
);

  // Arrays keep at least one entry so NUM_HPM = 0 still elaborates; the
  // spare entry is never addressed.
  localparam int unsigned HPM_N    = (NUM_HPM == 0) ? 1 : NUM_HPM;
  localparam logic [31:0] HPM_BITS = ((32'h1 << NUM_HPM) - 32'h1) << 3;
  localparam logic [31:0] INH_MASK = 32'h5 | HPM_BITS;

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  // Replace one 32-bit half; upper bits beyond COUNTER_WIDTH are dropped.
  function automatic cnt_t wr_half(input cnt_t cur, input logic hi, input logic [31:0] data);
    logic [63:0] ext;
    ext = 64'(cur);
    if (hi) ext[63:32] = data;
    else    ext[31:0]  = data;
    return ext[COUNTER_WIDTH-1:0];
  endfunction

  // Upper half is zero-extended when COUNTER_WIDTH < 64.
  function automatic logic [31:0] rd_half(input cnt_t cur, input logic hi);
    logic [63:0] ext;
    ext = 64'(cur);
    return hi ? ext[63:32] : ext[31:0];
  endfunction

  cnt_t        mcycle_q, mcycle_d;
  cnt_t        minstret_q, minstret_d;
  cnt_t        hpm_q [HPM_N];
  cnt_t        hpm_d [HPM_N];
  logic [7:0]  sel_q [HPM_N];
  logic [7:0]  sel_d [HPM_N];
  logic        ovie_q [HPM_N];
  logic        ovie_d [HPM_N];
  logic [31:0] inhibit_q, inhibit_d;
  logic [31:0] ovf_q, ovf_d;
  logic [31:0] ovf_set, ovf_clr;
  logic        hpm_hit [HPM_N];

  // Selected event per counter; select 0 or above NUM_EVENTS never matches.
  always_comb begin
    for (int unsigned i = 0; i < HPM_N; i++) begin
      hpm_hit[i] = 1'b0;
      for (int unsigned j = 0; j < NUM_EVENTS; j++) begin
        if (sel_q[i] == 8'(j + 1) && events[j]) hpm_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    hpm_d      = hpm_q;
    sel_d      = sel_q;
    ovie_d     = ovie_q;
    inhibit_d  = inhibit_q;
    ovf_set    = '0;
    ovf_clr    = '0;

    if (csrWriteEnable && (csrWriteAddress == 12'hB00 || csrWriteAddress == 12'hB80))
      mcycle_d = wr_half(mcycle_q, csrWriteAddress[7], csrWriteData);
    else if (!inhibit_q[0])
      mcycle_d = mcycle_q + cnt_t'(1);

    if (csrWriteEnable && (csrWriteAddress == 12'hB02 || csrWriteAddress == 12'hB82))
      minstret_d = wr_half(minstret_q, csrWriteAddress[7], csrWriteData);
    else if (instructionCompleted && !inhibit_q[2])
      minstret_d = minstret_q + cnt_t'(1);

    if (csrWriteEnable && csrWriteAddress == 12'h320)
      inhibit_d = csrWriteData & INH_MASK;

    if (csrWriteEnable && csrWriteAddress == 12'h7C0)
      ovf_clr = csrWriteData & HPM_BITS;

    for (int unsigned i = 0; i < NUM_HPM; i++) begin
      if (csrWriteEnable && (csrWriteAddress == 12'(32'hB03 + i) ||
                             csrWriteAddress == 12'(32'hB83 + i))) begin
        hpm_d[i] = wr_half(hpm_q[i], csrWriteAddress[7], csrWriteData);
      end else if (hpm_hit[i] && !inhibit_q[3 + i]) begin
        hpm_d[i] = hpm_q[i] + cnt_t'(1);
        if (hpm_q[i] == '1) ovf_set[3 + i] = 1'b1;
      end
      if (csrWriteEnable && csrWriteAddress == 12'(32'h323 + i)) begin
        sel_d[i]  = csrWriteData[7:0];
        ovie_d[i] = csrWriteData[31];
      end
    end

    // Set wins over a same-edge write-1-clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inhibit_q  <= '0;
      ovf_q      <= '0;
      for (int unsigned i = 0; i < HPM_N; i++) begin
        hpm_q[i]  <= '0;
        sel_q[i]  <= '0;
        ovie_q[i] <= 1'b0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inhibit_q  <= inhibit_d;
      ovf_q      <= ovf_d;
      hpm_q      <= hpm_d;
      sel_q      <= sel_d;
      ovie_q     <= ovie_d;
    end
  end

  always_comb begin
    csrReadData      = '0;
    csrRequestOutput = 1'b0;
    if (csrReadEnable) begin
      case (csrReadAddress)
        12'hB00, 12'hB80, 12'hC00, 12'hC80, 12'hC01, 12'hC81: begin
          csrRequestOutput = 1'b1;
          csrReadData      = rd_half(mcycle_q, csrReadAddress[7]);
        end
        12'hB02, 12'hB82, 12'hC02, 12'hC82: begin
          csrRequestOutput = 1'b1;
          csrReadData      = rd_half(minstret_q, csrReadAddress[7]);
        end
        12'h320: begin
          csrRequestOutput = 1'b1;
          csrReadData      = inhibit_q;
        end
        12'h7C0: begin
          csrRequestOutput = 1'b1;
          csrReadData      = ovf_q;
        end
        default: ;
      endcase
      for (int unsigned i = 0; i < NUM_HPM; i++) begin
        if (csrReadAddress == 12'(32'hB03 + i) || csrReadAddress == 12'(32'hB83 + i) ||
            csrReadAddress == 12'(32'hC03 + i) || csrReadAddress == 12'(32'hC83 + i)) begin
          csrRequestOutput = 1'b1;
          csrReadData      = rd_half(hpm_q[i], csrReadAddress[7]);
        end
        if (csrReadAddress == 12'(32'h323 + i)) begin
          csrRequestOutput = 1'b1;
          csrReadData      = {ovie_q[i], 23'b0, sel_q[i]};
        end
      end
    end
  end

  always_comb begin
    overflowInterrupt = 1'b0;
    for (int unsigned i = 0; i < NUM_HPM; i++)
      overflowInterrupt = overflowInterrupt | (ovf_q[3 + i] & ovie_q[i]);
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank: directed bench for csr_counter_bank (default params).
//   The driver issues CSR reads/writes shortly after each rising edge and
//   queues the expected read response; the monitor samples on the falling
//   edge whenever a read is presented and compares against the queue head.
module tb_csr_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csrWriteEnable = 1'b0;
  logic [11:0] csrWriteAddress = '0;
  logic [31:0] csrWriteData = '0;
  logic        csrReadEnable = 1'b0;
  logic [11:0] csrReadAddress = '0;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;
  logic        instructionCompleted = 1'b0;
  logic [7:0]  events = '0;
  logic        overflowInterrupt;

  csr_counter_bank #(.NUM_HPM(4), .COUNTER_WIDTH(64), .NUM_EVENTS(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .csrWriteEnable      (csrWriteEnable),
    .csrWriteAddress     (csrWriteAddress),
    .csrWriteData        (csrWriteData),
    .csrReadEnable       (csrReadEnable),
    .csrReadAddress      (csrReadAddress),
    .csrReadData         (csrReadData),
    .csrRequestOutput    (csrRequestOutput),
    .instructionCompleted(instructionCompleted),
    .events              (events),
    .overflowInterrupt   (overflowInterrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] data;
    logic        chk_irq;
    logic        irq;
  } exp_t;

  exp_t        sb[$];
  string       names[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  always @(negedge clk) begin
    if (csrReadEnable) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_read addr=%h got data=%h req=%b want queued entry",
                 csrReadAddress, csrReadData, csrRequestOutput);
      end else begin
        exp_t  e;
        string n;
        e = sb.pop_front();
        n = names.pop_front();
        tests++;
        if (csrReadData !== e.data) begin
          fails++;
          $display("FAIL %s data got=%h want=%h", n, csrReadData, e.data);
        end
        tests++;
        if (csrRequestOutput !== e.req) begin
          fails++;
          $display("FAIL %s req got=%b want=%b", n, csrRequestOutput, e.req);
        end
        if (e.chk_irq) begin
          tests++;
          if (overflowInterrupt !== e.irq) begin
            fails++;
            $display("FAIL %s irq got=%b want=%b", n, overflowInterrupt, e.irq);
          end
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [11:0] a, input logic req, input logic [31:0] d,
                    input logic ci, input logic irq, input string n);
    exp_t e;
    e.req = req; e.data = d; e.chk_irq = ci; e.irq = irq;
    sb.push_back(e);
    names.push_back(n);
    csrReadEnable  = 1'b1;
    csrReadAddress = a;
    step(1);
    csrReadEnable  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csrWriteEnable  = 1'b1;
    csrWriteAddress = a;
    csrWriteData    = d;
    step(1);
    csrWriteEnable  = 1'b0;
  endtask

  task automatic rdwr(input logic [11:0] a, input logic [31:0] wd, input logic [31:0] rd_exp,
                      input string n);
    exp_t e;
    e.req = 1'b1; e.data = rd_exp; e.chk_irq = 1'b0; e.irq = 1'b0;
    sb.push_back(e);
    names.push_back(n);
    csrReadEnable   = 1'b1;
    csrReadAddress  = a;
    csrWriteEnable  = 1'b1;
    csrWriteAddress = a;
    csrWriteData    = wd;
    step(1);
    csrReadEnable  = 1'b0;
    csrWriteEnable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset release and free-running mcycle
    step(10);
    rd(12'hB00, 1'b1, 32'd10, 1'b1, 1'b0, "mcycle_after_10");
    rd(12'hB80, 1'b1, 32'd0,  1'b0, 1'b0, "mcycleh_zero");
    rd(12'hB02, 1'b1, 32'd0,  1'b0, 1'b0, "minstret_zero");

    // Event selection: only events[1] counts on hpm3
    wr(12'h323, 32'h0000_0002);
    events = 8'h02; step(5);
    events = 8'h01; step(3);
    events = 8'h00;
    rd(12'hB03, 1'b1, 32'd5, 1'b0, 1'b0, "hpm3_sel_ev1");
    rd(12'hC03, 1'b1, 32'd5, 1'b0, 1'b0, "hpm3_user_alias");
    wr(12'hC03, 32'h0000_0077);
    rd(12'hB03, 1'b1, 32'd5, 1'b0, 1'b0, "alias_write_ignored");
    rd(12'hB83, 1'b1, 32'd0, 1'b0, 1'b0, "hpm3h_zero");
    rd(12'h323, 1'b1, 32'h0000_0002, 1'b0, 1'b0, "mhpmevent3_rb");

    // 64-bit wrap sets overflow flag and interrupt
    wr(12'h323, 32'h8000_0001);
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFE);
    events = 8'h01; step(2);
    events = 8'h00;
    rd(12'hB03, 1'b1, 32'd0, 1'b1, 1'b1, "hpm3_wrap_lo");
    rd(12'hB83, 1'b1, 32'd0, 1'b0, 1'b0, "hpm3_wrap_hi");
    rd(12'h7C0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, "ovf_set");
    rd(12'h323, 1'b1, 32'h8000_0001, 1'b0, 1'b0, "mhpmevent3_ovie_rb");
    wr(12'h7C0, 32'h0000_0008);
    rd(12'h7C0, 1'b1, 32'd0, 1'b1, 1'b0, "ovf_cleared");

    // Overflow and write-1-clear on the same edge: flag stays set
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    events = 8'h01;
    wr(12'h7C0, 32'h0000_0008);
    events = 8'h00;
    rd(12'h7C0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, "ovf_set_beats_clear");
    wr(12'h7C0, 32'h0000_0008);
    rd(12'h7C0, 1'b1, 32'd0, 1'b1, 1'b0, "ovf_cleared2");
    events = 8'h01; step(2);
    events = 8'h00;
    rd(12'hB03, 1'b1, 32'd2, 1'b0, 1'b0, "hpm3_after_wrap");

    // HPM3 inhibit
    wr(12'h320, 32'h0000_0008);
    events = 8'h01; step(2);
    events = 8'h00;
    rd(12'hB03, 1'b1, 32'd2, 1'b0, 1'b0, "hpm3_inhibited");

    // CY/IR inhibit then resume
    wr(12'h320, 32'h0000_0005);
    wr(12'hB00, 32'h0000_1234);
    wr(12'hB02, 32'h0000_0055);
    instructionCompleted = 1'b1; step(20);
    instructionCompleted = 1'b0;
    rd(12'hB00, 1'b1, 32'h0000_1234, 1'b0, 1'b0, "mcycle_inhibited");
    rd(12'hB02, 1'b1, 32'h0000_0055, 1'b0, 1'b0, "minstret_inhibited");
    rd(12'h320, 1'b1, 32'h0000_0005, 1'b0, 1'b0, "mcountinhibit_rb");
    wr(12'h320, 32'h0000_0000);
    instructionCompleted = 1'b1; step(3);
    instructionCompleted = 1'b0;
    rd(12'hB00, 1'b1, 32'h0000_1237, 1'b0, 1'b0, "mcycle_resumed");
    rd(12'hB02, 1'b1, 32'h0000_0058, 1'b0, 1'b0, "minstret_resumed");

    // Write priority over increment, and read-before-write on same cycle
    wr(12'hB00, 32'h0000_0100);
    rd(12'hB00, 1'b1, 32'h0000_0100, 1'b0, 1'b0, "mcycle_written");
    rd(12'hB00, 1'b1, 32'h0000_0101, 1'b0, 1'b0, "mcycle_written_plus1");
    rdwr(12'hB00, 32'h0000_0200, 32'h0000_0102, "read_pre_write_value");
    rd(12'hB00, 1'b1, 32'h0000_0200, 1'b0, 1'b0, "mcycle_post_write");
    rd(12'hB80, 1'b1, 32'd0, 1'b0, 1'b0, "mcycleh_unchanged");

    // Unimplemented HPM indices are not owned
    rd(12'hB07, 1'b0, 32'd0, 1'b0, 1'b0, "unowned_b07");
    rd(12'h327, 1'b0, 32'd0, 1'b0, 1'b0, "unowned_327");
    rd(12'hC07, 1'b0, 32'd0, 1'b0, 1'b0, "unowned_c07");
    wr(12'h323, 32'h8000_0001);

    // Asynchronous reset mid-count
    rst = 1'b0;
    rd(12'hB00, 1'b1, 32'd0, 1'b1, 1'b0, "rst_mcycle");
    rd(12'hB03, 1'b1, 32'd0, 1'b0, 1'b0, "rst_hpm3");
    rd(12'h323, 1'b1, 32'd0, 1'b0, 1'b0, "rst_mhpmevent3");
    rd(12'h320, 1'b1, 32'd0, 1'b0, 1'b0, "rst_mcountinhibit");
    rd(12'h7C0, 1'b1, 32'd0, 1'b1, 1'b0, "rst_mcountovf");
    rst = 1'b1;
    step(3);
    rd(12'hB00, 1'b1, 32'd3, 1'b0, 1'b0, "mcycle_after_rst");

    step(2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
